// File: rtl/lu_result_queue.sv
// rtl/lu_result_queue.sv - result capture and FIFO stage behind the 64-bit logical unit
module lu_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     rq_clk,
  input  logic                     rq_rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [2:0]               issue_opcode,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     flush,
  input  logic [63:0]              lu_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic [2:0]               res_opcode,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_zero,
  output logic                     res_ones,
  output logic                     res_parity,
  output logic [$clog2(DEPTH):0]   res_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [63:0]      data;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [2:0]       opcode;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               p_valid;
  logic [2:0]         p_opcode;
  logic [TAG_W-1:0]   p_tag;
  logic               ready_ok;
  logic [CNT_W:0]     occupancy;
  logic               accept;
  logic               pop;

  // Occupancy counts the in-flight op so the capture edge never sees a full FIFO.
  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, p_valid};
  assign issue_ready = ready_ok & ~rq_rst & (occupancy < DEPTH_V);
  assign accept      = issue_valid & issue_ready;
  assign res_valid   = (count != '0);
  assign pop         = res_valid & res_ready;
  assign res_count   = count;

  always_comb begin
    wr_entry        = '0;
    wr_entry.data   = lu_c;
    wr_entry.zero   = (lu_c == 64'd0);
    wr_entry.ones   = (lu_c == {64{1'b1}});
    wr_entry.parity = ^lu_c;
    wr_entry.opcode = p_opcode;
    wr_entry.tag    = p_tag;
  end

  // Head fields are masked when empty so stale entries never leak out after reset/flush.
  assign head       = mem[rd_ptr];
  assign res_data   = res_valid ? head.data   : 64'd0;
  assign res_opcode = res_valid ? head.opcode : 3'd0;
  assign res_tag    = res_valid ? head.tag    : '0;
  assign res_zero   = res_valid & head.zero;
  assign res_ones   = res_valid & head.ones;
  assign res_parity = res_valid & head.parity;

  always_ff @(posedge rq_clk) begin
    if (!rq_rst && !flush && p_valid) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge rq_clk) begin
    if (rq_rst) begin
      ready_ok <= 1'b0;
      p_valid  <= 1'b0;
      p_opcode <= 3'd0;
      p_tag    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_ok <= 1'b1;
      if (flush) begin
        p_valid <= 1'b0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        p_valid <= accept;
        if (accept) begin
          p_opcode <= issue_opcode;
          p_tag    <= issue_tag;
        end
        if (p_valid) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({p_valid, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lu_result_queue.sv
// tb/tb_lu_result_queue.sv - directed checks for lu_result_queue
module tb_lu_result_queue;

  logic        rq_clk = 1'b0;
  logic        rq_rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_opcode;
  logic [3:0]  issue_tag;
  logic        flush;
  logic [63:0] lu_c;
  logic [63:0] next_c;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [2:0]  res_opcode;
  logic [3:0]  res_tag;
  logic        res_zero;
  logic        res_ones;
  logic        res_parity;
  logic [2:0]  res_count;

  int checks = 0;
  int failures = 0;

  lu_result_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .rq_clk(rq_clk), .rq_rst(rq_rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_tag(issue_tag),
    .flush(flush), .lu_c(lu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode), .res_tag(res_tag),
    .res_zero(res_zero), .res_ones(res_ones), .res_parity(res_parity),
    .res_count(res_count)
  );

  always #5 rq_clk = ~rq_clk;

  // Stand-in for the logical unit: one registered cycle from operands to lu_c.
  always @(posedge rq_clk) lu_c <= next_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rq_clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [2:0]  opc;
    logic [63:0] c;
    logic        z;
    logic        o;
    logic        p;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acc;
    int sent;
    int rcv;
    int maxc;
    int low_ready;
    logic acc_now;

    vecs[0] = '{tag: 4'd3,  opc: 3'd1, c: 64'h0000_0000_0000_FF00, z: 1'b0, o: 1'b0, p: 1'b0};
    vecs[1] = '{tag: 4'd5,  opc: 3'd0, c: 64'h0,                   z: 1'b1, o: 1'b0, p: 1'b0};
    vecs[2] = '{tag: 4'd9,  opc: 3'd7, c: {64{1'b1}},             z: 1'b0, o: 1'b1, p: 1'b0};
    vecs[3] = '{tag: 4'd1,  opc: 3'd2, c: 64'h1,                   z: 1'b0, o: 1'b0, p: 1'b1};
    vecs[4] = '{tag: 4'd15, opc: 3'd4, c: 64'h8000_0000_0000_0003, z: 1'b0, o: 1'b0, p: 1'b1};
    vecs[5] = '{tag: 4'd0,  opc: 3'd6, c: 64'h7,                   z: 1'b0, o: 1'b0, p: 1'b1};

    rq_rst = 1'b1; issue_valid = 1'b0; issue_opcode = 3'd0; issue_tag = 4'd0;
    flush = 1'b0; next_c = 64'd0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_ready", issue_ready, 0);
    chk("rst_count", res_count, 0);
    chk("rst_data", res_data, 0);
    rq_rst = 1'b0;
    chk("rst_release_same_cycle_ready", issue_ready, 0);
    tick();
    chk("rst_release_next_ready", issue_ready, 1);

    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1; issue_tag = vecs[i].tag; issue_opcode = vecs[i].opc; next_c = vecs[i].c;
      tick();
      issue_valid = 1'b0; next_c = 64'd0;
      chk($sformatf("v%0d_cycle1_valid", i), res_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), res_valid, 1);
      chk($sformatf("v%0d_data", i), res_data, vecs[i].c);
      chk($sformatf("v%0d_tag", i), res_tag, vecs[i].tag);
      chk($sformatf("v%0d_opcode", i), res_opcode, vecs[i].opc);
      chk($sformatf("v%0d_zero", i), res_zero, vecs[i].z);
      chk($sformatf("v%0d_ones", i), res_ones, vecs[i].o);
      chk($sformatf("v%0d_parity", i), res_parity, vecs[i].p);
      chk($sformatf("v%0d_count", i), res_count, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk($sformatf("v%0d_drained", i), res_count, 0);
    end

    // Backpressure: consumer stalled, six back-to-back issues.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      issue_valid = 1'b1; issue_tag = 4'(k); issue_opcode = 3'(k); next_c = 64'h100 + 64'(k);
      chk($sformatf("bp_ready_%0d", k), issue_ready, (k < 4) ? 1 : 0);
      if (issue_ready) acc++;
      tick();
    end
    issue_valid = 1'b0;
    tick();
    chk("bp_accepted", acc, 4);
    chk("bp_count", res_count, 4);
    chk("bp_ready_full", issue_ready, 0);
    res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp_drain_valid_%0d", j), res_valid, 1);
      chk($sformatf("bp_drain_tag_%0d", j), res_tag, j);
      chk($sformatf("bp_drain_data_%0d", j), res_data, 64'h100 + 64'(j));
      tick();
    end
    res_ready = 1'b0;
    chk("bp_empty", res_valid, 0);
    chk("bp_ready_again", issue_ready, 1);

    // Streaming with a consumer that is always ready.
    sent = 0; rcv = 0; maxc = 0; low_ready = 0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rcv < 20; cyc++) begin
      if (sent < 20) begin
        issue_valid = 1'b1; issue_tag = sent[3:0]; issue_opcode = sent[2:0];
        next_c = 64'hA000 + 64'(sent);
        if (!issue_ready) low_ready++;
      end else begin
        issue_valid = 1'b0;
      end
      acc_now = issue_valid & issue_ready;
      if (res_valid) begin
        chk($sformatf("st_tag_%0d", rcv), res_tag, rcv[3:0]);
        chk($sformatf("st_data_%0d", rcv), res_data, 64'hA000 + 64'(rcv));
        chk($sformatf("st_opc_%0d", rcv), res_opcode, rcv[2:0]);
        rcv++;
      end
      if (int'(res_count) > maxc) maxc = int'(res_count);
      tick();
      if (acc_now) sent++;
    end
    issue_valid = 1'b0;
    res_ready = 1'b0;
    chk("st_received", rcv, 20);
    chk("st_max_count_le2", (maxc <= 2) ? 1 : 0, 1);
    chk("st_ready_never_low", low_ready, 0);

    // Flush with three queued and one in flight, plus an issue in the flush cycle.
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_tag = 4'(i); issue_opcode = 3'd2; next_c = 64'hB0 + 64'(i);
      tick();
    end
    chk("fl_pre_count", res_count, 3);
    flush = 1'b1; issue_valid = 1'b1; issue_tag = 4'd9; next_c = 64'hDEAD;
    tick();
    flush = 1'b0; issue_valid = 1'b0; next_c = 64'd0;
    chk("fl_valid", res_valid, 0);
    chk("fl_count", res_count, 0);
    chk("fl_ready", issue_ready, 1);
    tick();
    chk("fl_no_ghost", res_valid, 0);
    issue_valid = 1'b1; issue_tag = 4'd5; issue_opcode = 3'd3; next_c = 64'h5555;
    tick();
    issue_valid = 1'b0;
    tick();
    chk("fl_new_valid", res_valid, 1);
    chk("fl_new_tag", res_tag, 5);
    chk("fl_new_data", res_data, 64'h5555);
    chk("fl_new_count", res_count, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("fl_new_drained", res_count, 0);

    // Reset while two entries are queued.
    issue_valid = 1'b1; issue_tag = 4'd15; issue_opcode = 3'd7; next_c = {64{1'b1}};
    tick();
    issue_tag = 4'd6; issue_opcode = 3'd1; next_c = 64'h66;
    tick();
    issue_valid = 1'b0;
    tick();
    chk("rm_pre_count", res_count, 2);
    chk("rm_pre_ones", res_ones, 1);
    rq_rst = 1'b1;
    tick();
    chk("rm_valid", res_valid, 0);
    chk("rm_count", res_count, 0);
    chk("rm_ready", issue_ready, 0);
    chk("rm_data", res_data, 0);
    chk("rm_tag", res_tag, 0);
    chk("rm_opcode", res_opcode, 0);
    chk("rm_flags", {res_zero, res_ones, res_parity}, 0);
    rq_rst = 1'b0;
    chk("rm_release_same_cycle_ready", issue_ready, 0);
    tick();
    chk("rm_release_next_ready", issue_ready, 1);
    chk("rm_release_valid", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
